// File: rtl/bs_arb_mode_gen.sv
// Shared-bus arbiter: pops one packet from the winning driver FIFO, then pushes it
// to its destination port, or to every port but the source when it is a broadcast.

module bs_arb_mode_gen_lane #(
    parameter int         LANE      = 0,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic       pop_phase,
    input  logic       xfer_phase,
    input  logic       req,
    input  logic [7:0] grant,
    input  logic [7:0] dest,
    output logic       pop,
    output logic       push
);
    logic mine;

    assign mine = (grant == 8'(LANE));
    assign pop  = pop_phase && req && mine;
    // Broadcast skips the source; a unicast back to the source is still delivered.
    assign push = xfer_phase && ((dest == 8'(LANE)) || (dest == BROADCAST && !mine));
endmodule

module bs_arb_mode_gen #(
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF,
    parameter int         MODE      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]                pop,
    output logic [DRVRS-1:0]                push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
    output logic                            busy,
    output logic [7:0]                      grant_id,
    output logic [15:0]                     drop_cnt
);
    localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [1:0] {IDLE, POP, XFER} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        rr_ptr, winner, gsel;
    logic                 found;
    int                   idx;
    logic [PCKG_SZ-1:0]   pkt;
    logic [7:0]           dest;
    logic                 dest_bad;

    assign gsel     = grant_id[IW-1:0];
    assign dest     = pkt[PCKG_SZ-1 -: 8];
    assign dest_bad = (dest >= 8'(DRVRS)) && (dest != BROADCAST);
    assign busy     = (state != IDLE);

    // Scan starts at rr_ptr in round-robin mode and at 0 in fixed-priority mode.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < DRVRS; k++) begin
            idx = (MODE == 0) ? (int'(rr_ptr) + k) % DRVRS : k;
            if (!found && pndng[idx[IW-1:0]]) begin
                winner = idx[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pndng) state_nxt = POP;
            POP:     state_nxt = pndng[gsel] ? XFER : IDLE;
            XFER:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            pkt      <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |pndng)
                grant_id <= 8'(winner);
            if (state == POP && pndng[gsel])
                pkt <= D_pop[gsel];
            if (state == XFER) begin
                if (MODE == 0)
                    rr_ptr <= (gsel == IW'(DRVRS-1)) ? '0 : gsel + 1'b1;
                if (dest_bad && drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < DRVRS; i++) begin : g_lane
            bs_arb_mode_gen_lane #(.LANE(i), .BROADCAST(BROADCAST)) u_lane (
                .pop_phase  (state == POP),
                .xfer_phase (state == XFER),
                .req        (pndng[i]),
                .grant      (grant_id),
                .dest       (dest),
                .pop        (pop[i]),
                .push       (push[i])
            );
            assign D_push[i] = pkt;
        end
    endgenerate
endmodule

// File: tb/tb_bs_arb_mode_gen.sv
// Directed bench for bs_arb_mode_gen: a round-robin and a fixed-priority instance,
// with expected pushes queued at stimulus time and matched when the DUT pushes.

module tb_bs_arb_mode_gen;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [3:0]       pndng0, pndng1, pop0, pop1, push0, push1;
    logic [3:0][15:0] d_pop0, d_pop1, d_push0, d_push1;
    logic             busy0, busy1;
    logic [7:0]       grant0, grant1;
    logic [15:0]      drop0, drop1;

    logic [19:0] exp0[$], exp1[$];
    logic [19:0] e0, e1;
    int          pl0_idx[$], pl0_cyc[$], pl1_idx[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bs_arb_mode_gen #(.DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .pndng(pndng0), .D_pop(d_pop0), .pop(pop0), .push(push0),
        .D_push(d_push0), .busy(busy0), .grant_id(grant0), .drop_cnt(drop0));

    bs_arb_mode_gen #(.DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .pndng(pndng1), .D_pop(d_pop1), .pop(pop1), .push(push1),
        .D_push(d_push1), .busy(busy1), .grant_id(grant1), .drop_cnt(drop1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int which, input int n);
        int sz;
        for (int t = 0; t < 60; t++) begin
            sz = (which == 0) ? pl0_idx.size() : pl1_idx.size();
            if (sz >= n) break;
            tick(1);
        end
        sz = (which == 0) ? pl0_idx.size() : pl1_idx.size();
        chk($sformatf("pop_count_dut%0d", which), sz, n);
    endtask

    // One full transaction on dut0 with a single requester g.
    task automatic xact0(input int g);
        pl0_idx.delete(); pl0_cyc.delete();
        pndng0 = 4'(1 << g);
        tick(1);
        chk("pop_busy", busy0, 1);
        chk("pop_grant", grant0, g);
        chk("pop_strobe", pop0, 4'(1 << g));
        tick(1);
        chk("xfer_no_pop", pop0, 0);
        pndng0 = 4'b0000;
        tick(1);
        chk("idle_busy", busy0, 0);
        chk("idle_push", push0, 0);
        chk("pop_once", pl0_idx.size(), 1);
        chk("sb_drained", exp0.size(), 0);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (pop0[i]) begin pl0_idx.push_back(i); pl0_cyc.push_back(cyc); end
        if (push0 != 4'b0) begin
            chk("pop_push_excl0", pop0, 0);
            if (exp0.size() == 0) chk("unexpected_push0", push0, 0);
            else begin
                e0 = exp0.pop_front();
                chk("push0", push0, e0[19:16]);
                chk("dpush0_l0", d_push0[0], e0[15:0]);
                chk("dpush0_l3", d_push0[3], e0[15:0]);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (pop1[i]) pl1_idx.push_back(i);
        if (push1 != 4'b0) begin
            chk("pop_push_excl1", pop1, 0);
            if (exp1.size() == 0) chk("unexpected_push1", push1, 0);
            else begin
                e1 = exp1.pop_front();
                chk("push1", push1, e1[19:16]);
                chk("dpush1", d_push1[1], e1[15:0]);
            end
        end
    end

    initial begin
        reset = 1'b1; pndng0 = '0; pndng1 = '0; d_pop0 = '0; d_pop1 = '0;
        tick(2);
        chk("rst_pop", pop0, 0);
        chk("rst_push", push0, 0);
        chk("rst_dpush", d_push0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_grant", grant0, 0);
        chk("rst_drop", drop0, 0);
        reset = 1'b0;
        tick(1);

        // unicast 1 -> 2
        d_pop0[1] = 16'h02AB;
        exp0.push_back({4'b0100, 16'h02AB});
        xact0(1);
        chk("uni_hold", d_push0[2], 16'h02AB);
        chk("uni_drop", drop0, 0);

        // broadcast from 0
        d_pop0[0] = 16'hFF5A;
        exp0.push_back({4'b1110, 16'hFF5A});
        xact0(0);
        chk("bc_drop", drop0, 0);

        // invalid destination
        d_pop0[2] = 16'h0711;
        xact0(2);
        chk("bad_drop", drop0, 1);

        // saturation
        force dut0.drop_cnt = 16'hFFFF;
        tick(1);
        release dut0.drop_cnt;
        xact0(2);
        chk("sat_drop", drop0, 16'hFFFF);

        // round robin with all heads addressed to port 0
        reset = 1'b1;
        #1;
        chk("rst2_drop", drop0, 0);
        chk("rst2_grant", grant0, 0);
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) d_pop0[i] = 16'h0010 + 16'(i);
        for (int k = 0; k < 5; k++) exp0.push_back({4'b0001, 16'h0010 + 16'(k % 4)});
        pl0_idx.delete(); pl0_cyc.delete();
        pndng0 = 4'b1111;
        wait_n(0, 5);
        pndng0 = 4'b0000;
        tick(2);
        chk("rr_drained", exp0.size(), 0);
        for (int k = 0; k < 5 && k < pl0_idx.size(); k++)
            chk($sformatf("rr_grant%0d", k), pl0_idx[k], k % 4);
        for (int k = 1; k < 5 && k < pl0_cyc.size(); k++)
            chk($sformatf("rr_gap%0d", k), pl0_cyc[k] - pl0_cyc[k-1], 3);

        // abort in POP: requester withdraws, no pop and no capture
        d_pop0[1] = 16'h0123;
        pl0_idx.delete(); pl0_cyc.delete();
        pndng0 = 4'b0010;
        tick(1);
        chk("abort_grant", grant0, 1);
        pndng0 = 4'b0000;
        #1;
        chk("abort_nopop", pop0, 0);
        tick(1);
        chk("abort_idle", busy0, 0);
        chk("abort_popcnt", pl0_idx.size(), 0);
        chk("abort_nocapture", d_push0[0], 16'h0010);

        // reset during XFER
        d_pop0[1] = 16'h0234;
        pndng0 = 4'b0010;
        tick(2);
        pndng0 = 4'b0000;
        reset = 1'b1;
        #1;
        chk("rx_push", push0, 0);
        chk("rx_pop", pop0, 0);
        chk("rx_busy", busy0, 0);
        chk("rx_grant", grant0, 0);
        chk("rx_dpush", d_push0, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("rx_idle", busy0, 0);
        chk("rx_popcnt", pl0_idx.size(), 1);

        // fixed priority on dut1
        d_pop1[0] = 16'h0155;
        d_pop1[3] = 16'h0277;
        for (int k = 0; k < 3; k++) exp1.push_back({4'b0010, 16'h0155});
        exp1.push_back({4'b0100, 16'h0277});
        pl1_idx.delete();
        pndng1 = 4'b1001;
        wait_n(1, 3);
        for (int k = 0; k < 3 && k < pl1_idx.size(); k++)
            chk($sformatf("fp_grant%0d", k), pl1_idx[k], 0);
        pndng1 = 4'b1000;
        wait_n(1, 4);
        if (pl1_idx.size() >= 4) chk("fp_grant3", pl1_idx[3], 3);
        pndng1 = 4'b0000;
        tick(2);
        chk("fp_drained", exp1.size(), 0);
        chk("fp_last_grant", grant1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
